// File: rtl/neuron_mac_sequencer.sv
// Neuron MAC sequencer: walks operand memory, drives an external MAC, requantizes.
// Optional macro NEURON_RELU_EN clamps negative activations to zero.
module neuron_mac_sequencer #(
  parameter int N_INPUTS  = 784,
  parameter int ADDR_W    = 10,
  parameter int WIDTH_ACC = 32,
  parameter int WIDTH_OUT = 8,
  parameter int SHIFT     = 8
) (
  input  logic                        clk,
  input  logic                        aclr_n,
  input  logic                        start,
  input  logic signed [WIDTH_ACC-1:0] bias,
  input  logic signed [WIDTH_ACC-1:0] mac_result,
  output logic                        rd_en,
  output logic [ADDR_W-1:0]           rd_addr,
  output logic                        mac_clken,
  output logic                        mac_sload,
  output logic                        mac_aclr,
  output logic                        busy,
  output logic signed [WIDTH_OUT-1:0] act_out,
  output logic                        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_POST
  } state_t;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(N_INPUTS - 1);

  localparam logic signed [WIDTH_ACC:0] QMAX =
    $signed((WIDTH_ACC+1)'(2**(WIDTH_OUT-1) - 1));
  localparam logic signed [WIDTH_ACC:0] QMIN = ~QMAX;

  state_t state, state_nxt;
  logic   last;

  logic signed [WIDTH_ACC:0]   s;
  logic signed [WIDTH_ACC:0]   q;
  logic signed [WIDTH_OUT-1:0] sat;

  assign last     = (rd_addr == LAST);
  assign mac_aclr = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_POST;
      S_POST:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sum in one extra bit so bias cannot wrap before the shift.
  always_comb begin
    s = {mac_result[WIDTH_ACC-1], mac_result}
      + {bias[WIDTH_ACC-1], bias};
    q = s >>> SHIFT;
    sat = q[WIDTH_OUT-1:0];
    unique case (1'b1)
      (q > QMAX): sat = QMAX[WIDTH_OUT-1:0];
`ifdef NEURON_RELU_EN
      q[WIDTH_ACC]: sat = '0;
`else
      (q < QMIN): sat = QMIN[WIDTH_OUT-1:0];
`endif
      default: sat = q[WIDTH_OUT-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      mac_clken <= 1'b0;
      mac_sload <= 1'b0;
      done      <= 1'b0;
      act_out   <= '0;
    end else begin
      rd_en     <= (state_nxt == S_RUN);
      mac_clken <= rd_en;
      mac_sload <= rd_en && (rd_addr == '0);
      done      <= (state == S_POST);
      if (state == S_IDLE)
        rd_addr <= '0;
      else if (state == S_RUN && !last)
        rd_addr <= rd_addr + 1'b1;
      if (state == S_POST)
        act_out <= sat;
    end
  end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Directed bench for neuron_mac_sequencer, N_INPUTS=4, with a behavioural MAC.
// Expectations follow NEURON_RELU_EN when it is defined.
module tb_neuron_mac_sequencer;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int WA = 32;
  localparam int WO = 8;

  logic                 clk;
  logic                 aclr_n;
  logic                 start;
  logic signed [WA-1:0] bias;
  logic signed [WA-1:0] mac_result;
  logic                 rd_en;
  logic [AW-1:0]        rd_addr;
  logic                 mac_clken;
  logic                 mac_sload;
  logic                 mac_aclr;
  logic                 busy;
  logic signed [WO-1:0] act_out;
  logic                 done;

  logic signed [WA-1:0] prod_mem [N];
  logic signed [WA-1:0] pd;
  logic signed [WA-1:0] acc;

  int n_chk  = 0;
  int n_pass = 0;

  neuron_mac_sequencer #(
    .N_INPUTS (N),
    .ADDR_W   (AW),
    .WIDTH_ACC(WA),
    .WIDTH_OUT(WO),
    .SHIFT    (8)
  ) dut (
    .clk       (clk),
    .aclr_n    (aclr_n),
    .start     (start),
    .bias      (bias),
    .mac_result(mac_result),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .mac_clken (mac_clken),
    .mac_sload (mac_sload),
    .mac_aclr  (mac_aclr),
    .busy      (busy),
    .act_out   (act_out),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory with one-cycle read latency feeding an accumulator.
  always_ff @(posedge clk) begin
    if (rd_en) pd <= prod_mem[rd_addr[1:0]];
    if (mac_aclr)       acc <= '0;
    else if (mac_clken) acc <= mac_sload ? pd : acc + pd;
  end
  assign mac_result = acc;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " ctl"},
        {26'd0, rd_en, mac_clken, mac_sload, done, busy, mac_aclr},
        32'h1);
    chk({tag, " addr"}, 32'(rd_addr), 32'd0);
    chk({tag, " act"}, 32'(act_out), 32'd0);
  endtask

  task automatic load(input int p0, input int p1,
                      input int p2, input int p3, input int b);
    prod_mem[0] = p0;
    prod_mem[1] = p1;
    prod_mem[2] = p2;
    prod_mem[3] = p3;
    bias = b;
  endtask

  task automatic run_one(input string tag, input int exp_act);
    logic [5:0] e;
    @(negedge clk) start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      e = {k >= 1 && k <= 4, k >= 2 && k <= 5, k == 2,
           k == 7, k >= 1 && k <= 6, k == 0 || k >= 7};
      chk($sformatf("%s ctl c%0d", tag, k),
          {26'd0, rd_en, mac_clken, mac_sload, done, busy, mac_aclr},
          {26'd0, e});
      if (k <= 4)
        chk($sformatf("%s addr c%0d", tag, k),
            32'(rd_addr), 32'(k - 1));
      if (k >= 7)
        chk($sformatf("%s act c%0d", tag, k),
            32'(act_out), 32'(exp_act));
    end
  endtask

  initial begin
    aclr_n = 1'b0;
    start  = 1'b0;
    load(0, 0, 0, 0, 0);
    #12;
    chk_reset_vals("reset");
    @(negedge clk) aclr_n = 1'b1;

    load(256, 512, 768, 1024, 0);
    run_one("sum2560", 10);
    load(16384, 16384, 16384, 16384, 0);
    run_one("sat_pos", 127);
    load(-256, -256, -256, -256, 0);
`ifdef NEURON_RELU_EN
    run_one("neg1024", 0);
`else
    run_one("neg1024", -4);
`endif
    load(-16384, -16384, -16384, -16384, 0);
`ifdef NEURON_RELU_EN
    run_one("sat_neg", 0);
`else
    run_one("sat_neg", -128);
`endif
    load(256, 256, 256, 256, 256);
    run_one("bias", 5);
    load(0, 0, 0, 0, -1);
`ifdef NEURON_RELU_EN
    run_one("floor", 0);
`else
    run_one("floor", -1);
`endif
    load(32767, 0, 0, 0, 0);
    run_one("edge_max", 127);

    // start held high: back-to-back period of N+3
    load(256, 512, 768, 1024, 0);
    @(negedge clk) start = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      chk($sformatf("hold done c%0d", k),
          32'(done), 32'(k % 7 == 0));
      if (k % 7 == 0)
        chk($sformatf("hold act c%0d", k), 32'(act_out), 32'd10);
    end
    start = 1'b0;
    repeat (10) @(negedge clk);

    // asynchronous abort in cycle 3
    load(256, 256, 256, 256, 0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 aclr_n = 1'b0;
    #1 chk_reset_vals("abort");
    repeat (2) @(negedge clk);
    aclr_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("abort idle c%0d", k),
          {30'd0, done, act_out != 0}, 32'd0);
    end
    load(256, 512, 768, 1024, 512);
    run_one("restart", 12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/neuron_mac_sequencer.md
NEURON_MAC_SEQUENCER -- requirements
Module: neuron_mac_sequencer

Interface
REQ-001 Parameter N_INPUTS, default 784: MAC terms per neuron, range 1..2^ADDR_W.
REQ-002 Parameter ADDR_W, default 10: operand-memory address width.
REQ-003 Parameter WIDTH_ACC, default 32: accumulator/bias width, signed.
REQ-004 Parameter WIDTH_OUT, default 8: activation width, signed.
REQ-005 Parameter SHIFT, default 8: requantization right-shift, 0..WIDTH_ACC-1.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 aclr_n  in  1  reset, asynchronous, active-low.
REQ-008 start  in  1  request one neuron evaluation.
REQ-009 bias  in  WIDTH_ACC  signed bias, sampled in POST state.
REQ-010 mac_result  in  WIDTH_ACC  signed accumulator output of external MAC.
REQ-011 rd_en  out  1  read strobe to input and weight memories (1-cycle read latency).
REQ-012 rd_addr  out  ADDR_W  shared input/weight address.
REQ-013 mac_clken  out  1  MAC accumulate enable.
REQ-014 mac_sload  out  1  MAC restart: product replaces accumulator.
REQ-015 mac_aclr  out  1  MAC synchronous clear.
REQ-016 busy  out  1  high from cycle after start acceptance until done cycle.
REQ-017 act_out  out  WIDTH_OUT  signed activation, held until next done.
REQ-018 done  out  1  one-cycle pulse, act_out valid same cycle.

Function
REQ-019 States IDLE, RUN, DRAIN, POST; start sampled only in IDLE, ignored otherwise.
REQ-020 Start sampled at edge E0: rd_en=1, rd_addr=0..N_INPUTS-1 on cycles 1..N_INPUTS, one address per cycle, ascending, no gaps.
REQ-021 mac_clken = rd_en delayed one cycle (cycles 2..N_INPUTS+1); mac_sload=1 only with first mac_clken (cycle 2).
REQ-022 RUN->DRAIN after last address issued; DRAIN (last mac_clken) ->POST; POST->IDLE after one cycle.
REQ-023 In POST (cycle N_INPUTS+2): s = mac_result + bias in WIDTH_ACC+1 bits; q = s arithmetic-shift-right SHIFT (floor).
REQ-024 q clamped to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1] (subject to REQ-032), registered into act_out.
REQ-025 done=1 on cycle N_INPUTS+3 only; state is IDLE that cycle; start then accepted (back-to-back period N_INPUTS+3).
REQ-026 mac_aclr=1 exactly while state is IDLE; 0 in RUN, DRAIN, POST.
REQ-027 N_INPUTS=1: single rd_en cycle, mac_clken and mac_sload coincide, done at cycle 4.

Reset
REQ-028 aclr_n low forces IDLE immediately, independent of clk, including mid-RUN.
REQ-029 Reset values: rd_en 0, rd_addr 0, mac_clken 0, mac_sload 0, mac_aclr 1, busy 0, done 0, act_out 0, address counter 0.
REQ-030 Aborted evaluation produces no done pulse; act_out stays 0 until next completion.
REQ-031 First start accepted at first rising edge after aclr_n deasserts.

Configuration
REQ-032 Macro NEURON_RELU_EN defined: q<0 gives act_out=0, positive side clamped to 2^(WIDTH_OUT-1)-1; undefined: symmetric signed saturation per REQ-024.

Verification (N_INPUTS=4, SHIFT=8, WIDTH_OUT=8, behavioural MAC model)
REQ-033 Start pulse -> rd_addr 0,1,2,3 on cycles 1-4; mac_clken cycles 2-5; mac_sload cycle 2 only; done cycle 7.
REQ-034 Products 256,512,768,1024, bias 0 -> act_out=10, done=1 for one cycle.
REQ-035 Sum 0x10000, bias 0 -> act_out=127 (both configurations).
REQ-036 Sum -1024, bias 0 -> act_out=-4 without NEURON_RELU_EN, 0 with it; sum -65536 without macro -> -128.
REQ-037 start held high continuously -> done on cycles 7,14,21; start pulses during busy ignored.
REQ-038 aclr_n low on cycle 3 -> outputs at reset values same cycle, no done; restart after release completes normally.
